mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the multicycle CPU's data/instruction bus: accepts byte, halfword and word read/write requests over a valid/ready handshake, inserts a programmable number of wait states, and returns read data or an error flag over a second valid/ready channel. It replaces the fixed-latency memory behind the CPU's address mux so the control unit can be exercised against variable memory latency and faulting accesses.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words stored; valid byte addresses are 0 .. DEPTH_WORDS*4-1
- WAIT_CYCLES, 1, wait states between acceptance and response; legal range 0..15
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = write, 0 = read
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_addr  input  32  byte address
- req_wdata  input  32  write data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  output  1  response present
- rsp_ready  input  1  CPU accepts response
- rsp_rdata  output  32  read data, right-aligned, zero-extended; 0 for writes and errors
- rsp_err  output  1  access faulted

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. Handshake (req_valid && req_ready) latches write, size, addr, wdata; wait counter loads WAIT_CYCLES; go WAIT, or RESP directly when WAIT_CYCLES=0.
- WAIT: req_ready=0; counter decrements each cycle; on reaching 1, go RESP.
- Commit point: on the edge entering RESP, read data is sampled into rsp_rdata and writes are performed, both gated by error check.
- RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_ready=1; then go IDLE.
- Error conditions (any → rsp_err=1, no write, rsp_rdata=0): size 11; half with addr[0]=1; word with addr[1:0]≠0; addr ≥ DEPTH_WORDS*4.
- Byte lanes little-endian: byte at addr[1:0]=k occupies word bits [8k+7:8k]; half at addr[1]=h occupies [16h+15:16h].
- Byte/half writes modify only addressed lanes; other lanes retain old values.
- Word index = addr[31:2]; no wrap-around, out-of-range addresses fault.
- Read-after-write to same address in consecutive transactions returns the new value.
- Storage contents are not reset; reads of never-written words return X in simulation.

## Timing
- Request accepted in cycle N: rsp_valid first high in cycle N+1+WAIT_CYCLES.
- Response handshake in cycle M: req_ready high in cycle M+1 (one transaction outstanding maximum).
- req_valid while req_ready=0 is ignored; requester holds request.
- rsp_ready high while rsp_valid=0 has no effect.
- Reset asserted (reset=0): immediately state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0; req_ready returns to 1 the first cycle after reset deasserts.
- Reset during WAIT aborts the transaction: pending write is never committed. Reset during RESP discards the response; the write already occurred.

## Structure
- Shared package mem_resp_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, lane-enable/alignment function.
- Sub-module mem_word_array: DEPTH_WORDS×32 storage, synchronous write with 4 byte enables, combinational read by word index.
- Top handles FSM, wait counter, error check, lane alignment and zero-extension.

## Test plan
- WAIT_CYCLES=1: word write 0xDEADBEEF to 0x10, then word read 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after each acceptance.
- Byte write 0xAA to 0x11 over 0x11223344 at word 0x10, then word read → 0x1122AA44; byte read 0x13 → 0x00000011; half read 0x12 → 0x00001122.
- Errors: half read at 0x01, word write at 0x22, size 11, word read at DEPTH_WORDS*4 → each rsp_err=1, rsp_rdata=0, subsequent read of 0x20 unchanged.
- Backpressure: rsp_ready held 0 for 5 cycles → rsp_valid/rsp_rdata stable, req_ready=0 throughout; req_ready=1 cycle after rsp_ready pulse.
- WAIT_CYCLES=0 back-to-back reads → response cycle after acceptance, new acceptance cycle after each response handshake.
- WAIT_CYCLES=4: reset pulsed in WAIT of a write of 0x12345678 to 0x40 (previously 0x0) → all outputs 0 immediately; later read of 0x40 → 0x00000000.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared encodings and byte-lane helpers for the memory responder.
package mem_resp_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Right-aligned write data copied onto every lane; byte enables pick the live one.
    function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] addr_lo,
                                                 input logic [31:0] word);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        byte_sh = word >> {addr_lo, 3'b000};
        half_sh = word >> {addr_lo[1], 4'b0000};
        case (size)
            SZ_BYTE: return {24'b0, byte_sh[7:0]};
            SZ_HALF: return {16'b0, half_sh[15:0]};
            SZ_WORD: return word;
            default: return 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-organised storage: byte-enabled synchronous write, combinational read.
module mem_word_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [3:0]       i_be,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_responder.sv
// Bus-side memory responder with programmable wait states and access fault detection.
// state | meaning: IDLE accept request | WAIT count wait states | RESP hold response until taken
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    state_t      r_state;
    state_t      w_next;
    logic        r_rst_done;
    logic [3:0]  r_count;
    logic        r_write;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_cur_write;
    logic [1:0]  w_cur_size;
    logic [31:0] w_cur_addr;
    logic [31:0] w_cur_wdata;
    logic        w_err;
    logic        w_we;
    logic [31:0] w_rd_word;

    assign w_accept     = i_req_valid && o_req_ready;
    assign w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);

    // With zero wait states the commit edge is the acceptance edge, so use the live request.
    assign w_cur_write = (r_state == ST_IDLE) ? i_req_write : r_write;
    assign w_cur_size  = (r_state == ST_IDLE) ? i_req_size  : r_size;
    assign w_cur_addr  = (r_state == ST_IDLE) ? i_req_addr  : r_addr;
    assign w_cur_wdata = (r_state == ST_IDLE) ? i_req_wdata : r_wdata;

    assign w_err = (w_cur_size == SZ_RSVD)
                || misaligned(w_cur_size, w_cur_addr[1:0])
                || ({1'b0, w_cur_addr} >= ADDR_LIMIT);
    assign w_we  = w_enter_resp && w_cur_write && !w_err;

    mem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk    (clk),
        .i_we   (w_we),
        .i_be   (lane_enable(w_cur_size, w_cur_addr[1:0])),
        .i_idx  (w_cur_addr[IDX_W+1:2]),
        .i_wdata(lane_replicate(w_cur_size, w_cur_wdata)),
        .o_rdata(w_rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = (WAIT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_count <= 4'd1) w_next = ST_RESP;
            ST_RESP: if (i_rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (r_state == ST_IDLE) && r_rst_done;
        o_rsp_valid = (r_state == ST_RESP);
        o_rsp_rdata = r_rdata;
        o_rsp_err   = r_err;
    end

    // Holds req_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= WAIT_INIT;
        end else if (r_state == ST_WAIT && r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_size  <= SZ_BYTE;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_write <= i_req_write;
            r_size  <= i_req_size;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_err   <= w_err;
            r_rdata <= (!w_cur_write && !w_err)
                       ? lane_extract(w_cur_size, w_cur_addr[1:0], w_rd_word) : 32'b0;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (1, 0 and 4 wait states) against a byte-level memory model.
module tb_mem_responder;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] R = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [1:0]  req_size   [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        rsp_valid  [3];
    logic        rsp_ready  [3];
    logic [31:0] rsp_rdata  [3];
    logic        rsp_err    [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .DEPTH_WORDS(256),
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 4))
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .i_req_valid(req_valid[g]),
            .o_req_ready(req_ready[g]),
            .i_req_write(req_write[g]),
            .i_req_size (req_size[g]),
            .i_req_addr (req_addr[g]),
            .i_req_wdata(req_wdata[g]),
            .o_rsp_valid(rsp_valid[g]),
            .i_rsp_ready(rsp_ready[g]),
            .o_rsp_rdata(rsp_rdata[g]),
            .o_rsp_err  (rsp_err[g])
        );
    end

    function automatic int wc(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 4);
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  mdl     [3][1024];
    bit          pend    [3];
    bit          commit  [3];
    bit          rdone   [3];
    int          due     [3];
    bit          q_wr    [3];
    logic [1:0]  q_sz    [3];
    logic [31:0] q_a     [3];
    logic [31:0] q_wd    [3];
    logic [31:0] e_rd    [3];
    bit          e_err   [3];
    int          cyc = 0;
    bit          m_rdy;
    bit          m_vld;
    int          nb;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n[i]) begin
                chk("rst_req_ready", i, 32'(req_ready[i]), 32'd0);
                chk("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
                chk("rst_rsp_rdata", i, rsp_rdata[i], 32'd0);
                chk("rst_rsp_err",   i, 32'(rsp_err[i]), 32'd0);
                pend[i]  = 1'b0;
                rdone[i] = 1'b0;
            end else begin
                m_rdy = !pend[i] && rdone[i];
                m_vld = pend[i] && (cyc >= due[i]);
                chk("req_ready", i, 32'(req_ready[i]), 32'(m_rdy));
                chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(m_vld));
                if (m_vld) begin
                    chk("rsp_rdata", i, rsp_rdata[i], e_rd[i]);
                    chk("rsp_err",   i, 32'(rsp_err[i]), 32'(e_err[i]));
                end
                rdone[i] = 1'b1;
                if (m_vld && rsp_ready[i]) pend[i] = 1'b0;
                if (m_rdy && req_valid[i]) begin
                    pend[i]   = 1'b1;
                    commit[i] = 1'b0;
                    due[i]    = cyc + 1 + wc(i);
                    q_wr[i]   = req_write[i];
                    q_sz[i]   = req_size[i];
                    q_a[i]    = req_addr[i];
                    q_wd[i]   = req_wdata[i];
                end
                // the edge ending this cycle is the commit edge
                if (pend[i] && !commit[i] && due[i] == cyc + 1) begin
                    commit[i] = 1'b1;
                    nb = 1 << q_sz[i];
                    e_rd[i] = 32'd0;
                    e_err[i] = (q_sz[i] == 2'd3) || (q_sz[i] == 2'd1 && q_a[i] % 2 != 0)
                            || (q_sz[i] == 2'd2 && q_a[i] % 4 != 0) || (q_a[i] >= 32'd1024);
                    if (!e_err[i]) begin
                        for (int k = 0; k < nb; k++) begin
                            if (q_wr[i]) mdl[i][q_a[i] + k] = q_wd[i][8*k +: 8];
                            else         e_rd[i][8*k +: 8] = mdl[i][q_a[i] + k];
                        end
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic start_req(input int i, input bit wr, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input bit early_rdy, output int acc_wait);
        bit got;
        got = 1'b0;
        acc_wait = 0;
        req_write[i] = wr;
        req_size[i]  = sz;
        req_addr[i]  = a;
        req_wdata[i] = wd;
        req_valid[i] = 1'b1;
        rsp_ready[i] = early_rdy;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1'b1;
                break;
            end
            acc_wait++;
            @(posedge clk); #1;
        end
        if (!got) chk("accept_timeout", i, 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic finish_rsp(input int i, input int hold, output logic [31:0] rd, output bit er,
                              output int lat);
        bit got;
        got = 1'b0;
        lat = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid[i]) begin
                got = 1'b1;
                break;
            end
            lat++;
            @(posedge clk); #1;
        end
        if (!got) chk("response_timeout", i, 32'd0, 32'd1);
        rd = rsp_rdata[i];
        er = rsp_err[i];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_rsp_valid", i, 32'(rsp_valid[i]), 32'd1);
            chk("bp_req_ready", i, 32'(req_ready[i]), 32'd0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            rsp_ready[i] = 1'b1;
        end
        @(posedge clk); #1;
        rsp_ready[i] = 1'b0;
    endtask

    task automatic txn(input string nm, input int i, input bit wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input int hold,
                       input logic [31:0] x_rd, input bit x_er, input int x_lat);
        int          aw;
        int          lat;
        logic [31:0] rd;
        bit          er;
        start_req(i, wr, sz, a, wd, hold == 0, aw);
        finish_rsp(i, hold, rd, er, lat);
        chk({nm, "_accept_wait"}, i, 32'(aw), 32'd0);
        chk({nm, "_rdata"}, i, rd, x_rd);
        chk({nm, "_err"}, i, 32'(er), 32'(x_er));
        chk({nm, "_latency"}, i, 32'(lat), 32'(x_lat));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int aw;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_write[i] = 1'b0; req_size[i] = 2'b00;
            req_addr[i] = '0; req_wdata[i] = '0; rsp_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(posedge clk); #1;

        // one wait state: basic write/read, lanes, faults, boundary, backpressure
        txn("wr_deadbeef", 0, 1, W, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 2);
        txn("rd_deadbeef", 0, 0, W, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0, 2);
        txn("wr_11223344", 0, 1, W, 32'h10, 32'h11223344, 0, 32'h0, 0, 2);
        txn("wr_byte_aa",  0, 1, B, 32'h11, 32'h000000AA, 0, 32'h0, 0, 2);
        txn("rd_word_mix", 0, 0, W, 32'h10, 32'h0, 0, 32'h1122AA44, 0, 2);
        txn("rd_byte_13",  0, 0, B, 32'h13, 32'h0, 0, 32'h00000011, 0, 2);
        txn("rd_half_12",  0, 0, H, 32'h12, 32'h0, 0, 32'h00001122, 0, 2);
        txn("wr_cafe",     0, 1, W, 32'h20, 32'hCAFEF00D, 0, 32'h0, 0, 2);
        txn("err_half_01", 0, 0, H, 32'h01, 32'h0, 0, 32'h0, 1, 2);
        txn("err_word_22", 0, 1, W, 32'h22, 32'hFFFFFFFF, 0, 32'h0, 1, 2);
        txn("err_size_11", 0, 0, R, 32'h20, 32'h0, 0, 32'h0, 1, 2);
        txn("err_oob",     0, 0, W, 32'h400, 32'h0, 0, 32'h0, 1, 2);
        txn("rd_after_err", 0, 0, W, 32'h20, 32'h0, 0, 32'hCAFEF00D, 0, 2);
        txn("wr_half_22",  0, 1, H, 32'h22, 32'h1234BEEF, 0, 32'h0, 0, 2);
        txn("rd_half_mix", 0, 0, W, 32'h20, 32'h0, 0, 32'hBEEFF00D, 0, 2);
        txn("wr_last_byte", 0, 1, B, 32'h3FF, 32'h0000005A, 0, 32'h0, 0, 2);
        txn("rd_last_byte", 0, 0, B, 32'h3FF, 32'h0, 0, 32'h0000005A, 0, 2);
        txn("rd_backpress", 0, 0, W, 32'h10, 32'h0, 5, 32'h1122AA44, 0, 2);
        @(negedge clk);
        chk("ready_after_bp", 0, 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;

        // zero wait states: back-to-back traffic
        txn("z_wr0", 1, 1, W, 32'h00, 32'h01020304, 0, 32'h0, 0, 1);
        txn("z_wr4", 1, 1, W, 32'h04, 32'hA5A5A5A5, 0, 32'h0, 0, 1);
        txn("z_rd0", 1, 0, W, 32'h00, 32'h0, 0, 32'h01020304, 0, 1);
        txn("z_rd4", 1, 0, W, 32'h04, 32'h0, 0, 32'hA5A5A5A5, 0, 1);
        txn("z_rdh", 1, 0, H, 32'h02, 32'h0, 0, 32'h00000102, 0, 1);
        txn("z_rdb", 1, 0, B, 32'h07, 32'h0, 0, 32'h000000A5, 0, 1);

        // four wait states: reset aborts a pending write
        txn("l_wr40", 2, 1, W, 32'h40, 32'h00000000, 0, 32'h0, 0, 5);
        txn("l_wr44", 2, 1, W, 32'h44, 32'h0BADF00D, 0, 32'h0, 0, 5);
        txn("l_rd44", 2, 0, W, 32'h44, 32'h0, 0, 32'h0BADF00D, 0, 5);
        start_req(2, 1, W, 32'h40, 32'h12345678, 0, aw);
        @(posedge clk); #1;
        rst_n[2] = 1'b0;
        #1;
        chk("rst_now_req_ready", 2, 32'(req_ready[2]), 32'd0);
        chk("rst_now_rsp_valid", 2, 32'(rsp_valid[2]), 32'd0);
        chk("rst_now_rsp_rdata", 2, rsp_rdata[2], 32'd0);
        chk("rst_now_rsp_err",   2, 32'(rsp_err[2]), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n[2] = 1'b1;
        @(posedge clk); #1;
        txn("l_rd40", 2, 0, W, 32'h40, 32'h0, 0, 32'h00000000, 0, 5);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
